// File: rtl/demux_1x2_buf_if.sv
// Handshake bundle for demux_1x2_buf.
//   in_*    : tagged input stream (valid/ready, data, destination select)
//   y0_*    : channel 0 output stream (valid/ready, data) plus occupancy
//   y1_*    : channel 1 output stream (valid/ready, data) plus occupancy
// Modports: master = the environment (producer and both consumers), slave = the demux.
interface demux_1x2_buf_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;

    logic             y0_valid;
    logic             y0_ready;
    logic [WIDTH-1:0] y0_data;
    logic [CW-1:0]    y0_count;

    logic             y1_valid;
    logic             y1_ready;
    logic [WIDTH-1:0] y1_data;
    logic [CW-1:0]    y1_count;

    modport master (
        output in_valid, in_data, in_sel, y0_ready, y1_ready,
        input  in_ready, y0_valid, y0_data, y0_count, y1_valid, y1_data, y1_count
    );

    modport slave (
        input  in_valid, in_data, in_sel, y0_ready, y1_ready,
        output in_ready, y0_valid, y0_data, y0_count, y1_valid, y1_data, y1_count
    );
endinterface

// File: rtl/demux_1x2_buf.sv
// Buffered 1-to-2 demultiplexer: steers each accepted input word into one of two
// per-channel show-ahead FIFOs, each drained through its own valid/ready handshake.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; empties both FIFOs (storage not cleared)
//   bus   : demux_1x2_buf_if.slave (input stream, two output streams, occupancies)
module demux_1x2_buf #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input logic          clk,
    input logic          rst_n,
    demux_1x2_buf_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [CW-1:0]    cnt_q [2];
    logic [CW-1:0]    cnt_d [2];
    logic [PW-1:0]    wr_q  [2];
    logic [PW-1:0]    wr_d  [2];
    logic [PW-1:0]    rd_q  [2];
    logic [PW-1:0]    rd_d  [2];
    logic [WIDTH-1:0] mem   [2][DEPTH];

    logic [1:0] push;
    logic [1:0] pop;
    logic [1:0] full;
    logic [1:0] valid;
    logic [1:0] out_ready;
    logic       in_ready;

    always_comb begin
        push      = '0;
        pop       = '0;
        full      = '0;
        valid     = '0;
        out_ready = {bus.y1_ready, bus.y0_ready};
        for (int ch = 0; ch < 2; ch++) begin
            full[ch]  = (cnt_q[ch] == CW'(DEPTH));
            valid[ch] = (cnt_q[ch] != '0);
        end

        // Readiness follows the selected channel only; a full FIFO refuses even
        // when it is popping on the same edge, so in_ready stays off the pop path.
        in_ready = bus.in_sel ? !full[1] : !full[0];

        push[0] = bus.in_valid && in_ready && !bus.in_sel;
        push[1] = bus.in_valid && in_ready && bus.in_sel;

        for (int ch = 0; ch < 2; ch++) begin
            pop[ch]   = valid[ch] && out_ready[ch];
            wr_d[ch]  = push[ch] ? wr_q[ch] + PW'(1) : wr_q[ch];
            rd_d[ch]  = pop[ch]  ? rd_q[ch] + PW'(1) : rd_q[ch];
            cnt_d[ch] = cnt_q[ch];
            if (push[ch] && !pop[ch]) begin
                cnt_d[ch] = cnt_q[ch] + CW'(1);
            end else if (pop[ch] && !push[ch]) begin
                cnt_d[ch] = cnt_q[ch] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < 2; ch++) begin
                cnt_q[ch] <= '0;
                wr_q[ch]  <= '0;
                rd_q[ch]  <= '0;
            end
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                cnt_q[ch] <= cnt_d[ch];
                wr_q[ch]  <= wr_d[ch];
                rd_q[ch]  <= rd_d[ch];
            end
        end
    end

    // Storage is not reset; a slot is only exposed after it has been written.
    always_ff @(posedge clk) begin
        for (int ch = 0; ch < 2; ch++) begin
            if (push[ch]) begin
                mem[ch][wr_q[ch]] <= bus.in_data;
            end
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.y0_valid = valid[0];
    assign bus.y0_data  = mem[0][rd_q[0]];
    assign bus.y0_count = cnt_q[0];
    assign bus.y1_valid = valid[1];
    assign bus.y1_data  = mem[1][rd_q[1]];
    assign bus.y1_count = cnt_q[1];
endmodule
